// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code counter: the per-cycle command
// enum and binary/Gray conversion functions. The functions work on the
// widest legal counter width and are truncated by the caller.
package gray_pkg;

    localparam int MAX_W = 16;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_CLR,
        CMD_LOAD,
        CMD_UP,
        CMD_DOWN
    } cmd_t;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Watches consecutive gray_q values and flags any counting step that moved
// more than one bit. The flag is aligned with the offending new value.
module gray_step_check #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             skip,
    input  logic [WIDTH-1:0] gray_q,
    output logic             gray_err
);

    logic [WIDTH-1:0] prev;
    logic             pend;
    logic [WIDTH-1:0] diff;

    // Remember the value before each edge and whether that edge was a checked step
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= '0;
            pend <= 1'b0;
        end else begin
            prev <= gray_q;
            pend <= step && !skip;
        end
    end

    // More than one bit set in the difference means a multi-bit step
    always_comb begin
        diff     = gray_q ^ prev;
        gray_err = pend && ((diff & (diff - WIDTH'(1))) != '0);
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down modulo-N counter with registered binary and Gray outputs, wrap and
// out-of-range-load pulses. Defining GRAY_COUNTER_CHECK_EN adds the gray_err
// output and a step checker that flags multi-bit Gray transitions.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 2 ** WIDTH
) (
    input  logic             G_CLK_TX,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap,
    output logic             load_err
`ifdef GRAY_COUNTER_CHECK_EN
    ,
    output logic             gray_err
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam bit               IS_POW2 = ((MODULO & (MODULO - 1)) == 0);

    cmd_t             cmd;
    logic [WIDTH-1:0] bin_next;
    logic             wrap_next;
    logic             lerr_next;

    // Resolve the per-cycle command: clear beats load beats count
    always_comb begin
        cmd = CMD_HOLD;
        if (clr) begin
            cmd = CMD_CLR;
        end else if (load) begin
            cmd = CMD_LOAD;
        end else if (en) begin
            cmd = up_dn ? CMD_UP : CMD_DOWN;
        end
    end

    // Next count and the pulses that accompany it
    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        lerr_next = 1'b0;
        case (cmd)
            CMD_CLR: bin_next = '0;
            CMD_LOAD: begin
                if ({1'b0, load_val} >= MOD_W) begin
                    bin_next  = MAX_VAL;
                    lerr_next = 1'b1;
                end else begin
                    bin_next = load_val;
                end
            end
            CMD_UP: begin
                if (bin_q == MAX_VAL) begin
                    bin_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    bin_next = bin_q + ONE;
                end
            end
            CMD_DOWN: begin
                if (bin_q == '0) begin
                    bin_next  = MAX_VAL;
                    wrap_next = 1'b1;
                end else begin
                    bin_next = bin_q - ONE;
                end
            end
            default: ;
        endcase
    end

    // Binary and Gray outputs are registered together so they never skew
    always_ff @(posedge G_CLK_TX) begin
        if (!rst) begin
            bin_q    <= '0;
            gray_q   <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            bin_q    <= bin_next;
            gray_q   <= WIDTH'(bin2gray(MAX_W'(bin_next)));
            wrap     <= wrap_next;
            load_err <= lerr_next;
        end
    end

`ifdef GRAY_COUNTER_CHECK_EN
    logic step_chk;
    logic skip_chk;

    // Only plain count steps are checked; a non-power-of-two wrap is multi-bit by nature
    always_comb begin
        step_chk = (cmd == CMD_UP) || (cmd == CMD_DOWN);
        skip_chk = wrap_next && !IS_POW2;
    end

    gray_step_check #(
        .WIDTH(WIDTH)
    ) u_check (
        .clk     (G_CLK_TX),
        .rst     (rst),
        .step    (step_chk),
        .skip    (skip_chk),
        .gray_q  (gray_q),
        .gray_err(gray_err)
    );
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: a vector table on a 16-state counter plus
// hand sequences on a 10-state counter; with GRAY_COUNTER_CHECK_EN it also
// runs random count steps and expects gray_err to stay low.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, clr, load;
    logic [3:0] load_val;
    logic [3:0] bin16, gray16, bin10, gray10;
    logic       wrap16, lerr16, wrap10, lerr10;
`ifdef GRAY_COUNTER_CHECK_EN
    logic       gerr16, gerr10;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .MODULO(16)) dut16 (
        .G_CLK_TX(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .bin_q(bin16), .gray_q(gray16),
        .wrap(wrap16), .load_err(lerr16)
`ifdef GRAY_COUNTER_CHECK_EN
        , .gray_err(gerr16)
`endif
    );

    gray_counter #(.WIDTH(4), .MODULO(10)) dut10 (
        .G_CLK_TX(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .bin_q(bin10), .gray_q(gray10),
        .wrap(wrap10), .load_err(lerr10)
`ifdef GRAY_COUNTER_CHECK_EN
        , .gray_err(gerr10)
`endif
    );

    typedef struct {
        logic       rst, en, up_dn, clr, load;
        logic [3:0] load_val;
        logic [3:0] exp_bin, exp_gray;
        logic       exp_wrap, exp_lerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic u, logic c, logic l, logic [3:0] lv,
                                logic [3:0] b, logic [3:0] g, logic w, logic le);
        vec_t v;
        v.rst = r; v.en = e; v.up_dn = u; v.clr = c; v.load = l; v.load_val = lv;
        v.exp_bin = b; v.exp_gray = g; v.exp_wrap = w; v.exp_lerr = le;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic c,
                         input logic l, input logic [3:0] lv);
        rst = r; en = e; up_dn = u; clr = c; load = l; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk10(input string name, input int b, input int g, input int w, input int le);
        chk({name, "_bin"}, int'(bin10), b);
        chk({name, "_gray"}, int'(gray10), g);
        chk({name, "_wrap"}, int'(wrap10), w);
        chk({name, "_lerr"}, int'(lerr10), le);
    endtask

    // Hand-computed Gray codes of 0..15
    int gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;

        // reset state
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // 16 up steps: 1..15 then wrap to 0
        for (int n = 1; n <= 16; n++) begin
            vecs.push_back(mk(1, 1, 1, 0, 0, 0, 4'(n % 16), 4'(gtab[n % 16]), (n == 16), 0));
        end
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 0));     // 17th step, no wrap
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0));     // hold
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));     // down 1->0, no wrap
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 15, 8, 1, 0));    // down wrap 0->15
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0));     // immediate direction change
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));     // reset overrides en
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 15, 8, 1, 0));    // down from 0
        vecs.push_back(mk(1, 0, 1, 0, 1, 7, 7, 4, 0, 0));     // load 7
        vecs.push_back(mk(1, 1, 1, 1, 1, 3, 0, 0, 0, 0));     // clr+load+en at 7
        vecs.push_back(mk(1, 0, 1, 0, 1, 15, 15, 8, 0, 0));   // load MODULO-1, no wrap
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0));     // clr, no wrap
        for (int n = 1; n <= 5; n++) begin
            vecs.push_back(mk(1, 1, 1, 0, 0, 0, 4'(n), 4'(gtab[n]), 0, 0));
        end
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));     // mid-count reset at 5
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2, 3, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 10, 10, 15, 0, 0));  // load beats en
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 10, 15, 0, 0));   // hold

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].up_dn, vecs[i].clr, vecs[i].load, vecs[i].load_val);
            chk($sformatf("v%0d_bin", i), int'(bin16), int'(vecs[i].exp_bin));
            chk($sformatf("v%0d_gray", i), int'(gray16), int'(vecs[i].exp_gray));
            chk($sformatf("v%0d_wrap", i), int'(wrap16), int'(vecs[i].exp_wrap));
            chk($sformatf("v%0d_lerr", i), int'(lerr16), int'(vecs[i].exp_lerr));
        end

        // Modulo-10 corner sequences
        drive(0, 0, 1, 0, 0, 0);
        chk10("m10_rst", 0, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 12);
        chk10("m10_ld12", 9, 13, 0, 1);
        drive(1, 1, 1, 0, 0, 0);
        chk10("m10_upwrap", 0, 0, 1, 0);
        drive(1, 1, 0, 0, 0, 0);
        chk10("m10_dnwrap", 9, 13, 1, 0);
        drive(1, 1, 0, 0, 0, 0);
        chk10("m10_dn8", 8, 12, 0, 0);
        drive(1, 0, 1, 0, 1, 9);
        chk10("m10_ld9", 9, 13, 0, 0);
        drive(1, 0, 1, 0, 1, 10);
        chk10("m10_ld10", 9, 13, 0, 1);
        drive(1, 0, 1, 0, 0, 0);
        chk10("m10_hold", 9, 13, 0, 0);
        drive(1, 1, 1, 1, 1, 12);
        chk10("m10_clrld", 0, 0, 0, 0);
        for (int n = 1; n <= 9; n++) begin
            drive(1, 1, 1, 0, 0, 0);
            chk10($sformatf("m10_up%0d", n), n, gtab[n], 0, 0);
        end
        drive(1, 1, 1, 0, 0, 0);
        chk10("m10_wrap2", 0, 0, 1, 0);

`ifdef GRAY_COUNTER_CHECK_EN
        drive(0, 0, 1, 0, 0, 0);
        chk("gerr_rst16", int'(gerr16), 0);
        chk("gerr_rst10", int'(gerr10), 0);
        for (int n = 0; n < 100; n++) begin
            drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0);
            chk($sformatf("gerr16_%0d", n), int'(gerr16), 0);
            chk($sformatf("gerr10_%0d", n), int'(gerr10), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
